collision_scanner: RTL and testbench
====================================

// Module: collision_scanner
// PURPOSE
//   Time-multiplexed player-vs-hazard collision engine, parametrised in object count and radii.
//   Once per frame, on start, it snapshots the kid position and scans N_OBJ objects, one per clock, with a single squared-distance unit.
//   Per object it applies a kind-specific kill/visit rule, then publishes a sticky kill flag, a per-frame visited flag and the first hit index.
//   Sits between the object position generators and the game-state FSM; start is driven from frame sync.
// PARAMETERS
//   N_OBJ        26   number of scanned objects (index 0..N_OBJ-1)
//   W            10   coordinate width, unsigned pixels
//   KID_SIZE     15   kid radius
//   OBJ_SIZE     15   object radius
//   SHRINK_S     7    kill-radius trim, kind 0 (static)
//   SHRINK_M     4    kill-radius trim, kind 1 (moving/boundary)
//   VISIT_MARGIN 14   extra radius for visit detection
//   VISIT_CNT    4    kind-0 objects with index < VISIT_CNT also test visit
// PORTS
//   Clk         in   1             system clock, rising edge
//   Reset       in   1             asynchronous, active-low reset
//   start       in   1             one-cycle scan request
//   kid_x       in   W             kid centre x, sampled on accepted start
//   kid_y       in   W             kid centre y, sampled on accepted start
//   obj_x       in   N_OBJ*W       packed object x, [i*W +: W]
//   obj_y       in   N_OBJ*W       packed object y
//   obj_kind    in   N_OBJ*2       0 static, 1 moving, 2 checkpoint (visit only), 3 ignore
//   force_kill  in   1             external kill (save==01 path), sampled on accepted start
//   kill_clr    in   1             clears sticky is_kill
//   busy        out  1             scan in progress
//   done        out  1             one-cycle pulse, results updated this cycle
//   is_kill     out  1             sticky kill flag
//   visited     out  1             visit result of the last completed scan
//   hit_valid   out  1             last scan found a kill-radius hit
//   hit_idx     out  $clog2(N_OBJ) lowest hit index, last scan
// BEHAVIOUR
//   - Reset (any time, including mid-scan): FSM=IDLE, index=0, all outputs 0.
//   - FSM: IDLE -start-> SCAN; SCAN at index N_OBJ-1 -> DONE; DONE -> IDLE (one cycle).
//   - start is accepted only in IDLE. On acceptance: latch kid_x/y and force_kill, clear frame
//     accumulators, index=0. start while busy or in DONE is ignored, not queued.
//   - SCAN: cycle k reads object k live. Objects must stay stable from start to done.
//   - Arithmetic: dx = kid_x - obj_x in signed W+1 bits; same for dy. d2 = dx*dx + dy*dy
//     in unsigned 2W+3 bits, no truncation. Radii are computed from parameters at elaboration:
//     Rs = KID_SIZE+OBJ_SIZE-SHRINK_S, Rm = KID_SIZE+OBJ_SIZE-SHRINK_M, Rv = Rs+VISIT_MARGIN.
//   - Rules use <= (boundary counts as a hit):
//     - kind 0: kill if d2<=Rs^2; visit if k<VISIT_CNT and d2<=Rv^2.
//     - kind 1: kill if d2<=Rm^2.
//     - kind 2: visit if d2<=Rv^2, never kill.
//     - kind 3: no effect.
//   - hit_idx records the first (lowest) kill index; later hits do not overwrite it.
//   - Latency: start accepted at cycle 0, busy=1 for cycles 1..N_OBJ, done=1 at cycle N_OBJ+1.
//     In the done cycle, busy=0 and visited, hit_valid and hit_idx are updated.
//   - is_kill is set at done if hit_valid or latched force_kill, and holds until kill_clr.
//     If kill_clr and a setting done occur in the same cycle, set wins.
//     kill_clr alone clears is_kill on the next edge, in any state.
//   - visited, hit_valid and hit_idx hold between scans. A scan with no hits clears them; hit_idx returns to 0.
// TESTING
//   - Reset mid-scan (index 10): next cycle busy=0, is_kill=0; later done never pulses for that scan.
//   - Kid (100,100), obj0 kind0 at (116,116), d2=512<=529: done at cycle 27, is_kill=1, hit_idx=0, visited=1.
//   - Kid (100,100), obj0 kind0 at (117,116), d2=545: no kill, visited=1 (<=1369). Same object at idx 5: visited=0.
//   - Kid (0,0), obj3 kind1 at (26,0), d2=676=Rm^2: hit. obj7 also hits: hit_idx stays 3.
//   - Kind2 at (100,100) vs kid (100,100): visited=1, is_kill=0. Kind3 there instead: both 0.
//   - force_kill=1 at start, no objects near: is_kill=1, hit_valid=0. kill_clr and done together: is_kill stays 1.

Source files
------------

// File: rtl/collision_scanner.sv
// Player-vs-hazard collision engine: one object per clock through a
// single squared-distance unit, with sticky kill and per-frame visit flags.
module collision_scanner #(
    parameter int N_OBJ        = 26,
    parameter int W            = 10,
    parameter int KID_SIZE     = 15,
    parameter int OBJ_SIZE     = 15,
    parameter int SHRINK_S     = 7,
    parameter int SHRINK_M     = 4,
    parameter int VISIT_MARGIN = 14,
    parameter int VISIT_CNT    = 4,
    localparam int IW          = $clog2(N_OBJ)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [W-1:0]         kid_x,
    input  logic [W-1:0]         kid_y,
    input  logic [N_OBJ*W-1:0]   obj_x,
    input  logic [N_OBJ*W-1:0]   obj_y,
    input  logic [N_OBJ*2-1:0]   obj_kind,
    input  logic                 force_kill,
    input  logic                 kill_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 is_kill,
    output logic                 visited,
    output logic                 hit_valid,
    output logic [IW-1:0]        hit_idx
);

    localparam int D2W = 2*W + 3;
    localparam int RS  = KID_SIZE + OBJ_SIZE - SHRINK_S;
    localparam int RM  = KID_SIZE + OBJ_SIZE - SHRINK_M;
    localparam int RV  = RS + VISIT_MARGIN;
    localparam logic [D2W-1:0] RS2 = D2W'(RS*RS);
    localparam logic [D2W-1:0] RM2 = D2W'(RM*RM);
    localparam logic [D2W-1:0] RV2 = D2W'(RV*RV);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_OBJ-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_kid_x;
    logic [W-1:0]    r_kid_y;
    logic            r_force;
    logic            r_acc_hit;
    logic [IW-1:0]   r_acc_idx;
    logic            r_acc_vis;
    logic            r_set;

    logic [W-1:0]    w_ox [N_OBJ];
    logic [W-1:0]    w_oy [N_OBJ];
    logic [1:0]      w_kd [N_OBJ];

    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            w_ox[i] = obj_x[i*W +: W];
            w_oy[i] = obj_y[i*W +: W];
            w_kd[i] = obj_kind[i*2 +: 2];
        end
    end

    logic [W:0]      w_dx;
    logic [W:0]      w_dy;
    logic [W:0]      w_ndx;
    logic [W:0]      w_ndy;
    logic [W-1:0]    w_adx;
    logic [W-1:0]    w_ady;
    logic [D2W-1:0]  w_d2;
    logic [1:0]      w_kind;
    logic            w_kill;
    logic            w_vis;
    logic            w_low;

    // Squares of |d| equal squares of signed d, so fold sign away first.
    assign w_dx  = {1'b0, r_kid_x} - {1'b0, w_ox[r_idx]};
    assign w_dy  = {1'b0, r_kid_y} - {1'b0, w_oy[r_idx]};
    assign w_ndx = -w_dx;
    assign w_ndy = -w_dy;
    assign w_adx = w_dx[W] ? w_ndx[W-1:0] : w_dx[W-1:0];
    assign w_ady = w_dy[W] ? w_ndy[W-1:0] : w_dy[W-1:0];
    assign w_d2  = D2W'(w_adx) * D2W'(w_adx)
                 + D2W'(w_ady) * D2W'(w_ady);
    assign w_kind = w_kd[r_idx];
    assign w_low  = 32'(r_idx) < 32'(VISIT_CNT);

    always_comb begin
        w_kill = 1'b0;
        w_vis  = 1'b0;
        unique case (w_kind)
            2'd0: begin
                w_kill = (w_d2 <= RS2);
                w_vis  = w_low && (w_d2 <= RV2);
            end
            2'd1: w_kill = (w_d2 <= RM2);
            2'd2: w_vis  = (w_d2 <= RV2);
            default: ;
        endcase
    end

    logic            w_last;
    logic            w_hit_fin;
    logic [IW-1:0]   w_idx_fin;
    logic            w_set_fin;

    assign w_last    = (r_idx == LAST_IDX);
    assign w_hit_fin = r_acc_hit | w_kill;
    assign w_idx_fin = r_acc_hit ? r_acc_idx :
                       (w_kill ? r_idx : '0);
    assign w_set_fin = w_hit_fin | r_force;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_kid_x   <= '0;
            r_kid_y   <= '0;
            r_force   <= 1'b0;
            r_acc_hit <= 1'b0;
            r_acc_idx <= '0;
            r_acc_vis <= 1'b0;
            r_set     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            is_kill   <= 1'b0;
            visited   <= 1'b0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
        end else begin
            // A clear that lands on the setting done loses to the set.
            if (kill_clr && !(done && r_set))
                is_kill <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_kid_x   <= kid_x;
                        r_kid_y   <= kid_y;
                        r_force   <= force_kill;
                        r_acc_hit <= 1'b0;
                        r_acc_idx <= '0;
                        r_acc_vis <= 1'b0;
                        r_idx     <= '0;
                        busy      <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_kill && !r_acc_hit) begin
                        r_acc_hit <= 1'b1;
                        r_acc_idx <= r_idx;
                    end
                    if (w_vis)
                        r_acc_vis <= 1'b1;
                    if (w_last) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        hit_valid <= w_hit_fin;
                        hit_idx   <= w_idx_fin;
                        visited   <= r_acc_vis | w_vis;
                        r_set     <= w_set_fin;
                        if (w_set_fin)
                            is_kill <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_set   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed and randomized checks of collision_scanner against a
// distance-rule model computed with plain integer arithmetic.
module tb_collision_scanner;

    localparam int N = 26;
    localparam int W = 10;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   kid_x = '0;
    logic [W-1:0]   kid_y = '0;
    logic [N*W-1:0] obj_x;
    logic [N*W-1:0] obj_y;
    logic [N*2-1:0] obj_kind;
    logic           force_kill = 1'b0;
    logic           kill_clr = 1'b0;
    logic           busy;
    logic           done;
    logic           is_kill;
    logic           visited;
    logic           hit_valid;
    logic [4:0]     hit_idx;

    int ox [N];
    int oy [N];
    int kd [N];

    int tests = 0;
    int fails = 0;
    int lat;
    bit e_hit;
    bit e_vis;
    int e_idx;
    bit m_kill = 0;

    collision_scanner dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .kid_x(kid_x), .kid_y(kid_y),
        .obj_x(obj_x), .obj_y(obj_y), .obj_kind(obj_kind),
        .force_kill(force_kill), .kill_clr(kill_clr),
        .busy(busy), .done(done), .is_kill(is_kill),
        .visited(visited), .hit_valid(hit_valid), .hit_idx(hit_idx)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        obj_x = '0;
        obj_y = '0;
        obj_kind = '0;
        for (int i = 0; i < N; i++) begin
            obj_x[i*W +: W]  = W'(ox[i]);
            obj_y[i*W +: W]  = W'(oy[i]);
            obj_kind[i*2 +: 2] = 2'(kd[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_objs();
        for (int i = 0; i < N; i++) begin
            ox[i] = 1000;
            oy[i] = 1000;
            kd[i] = 3;
        end
    endtask

    // Rules straight from the radii: Rs=23, Rm=26, Rv=37.
    task automatic model(input int kx, input int ky);
        int d2;
        e_hit = 0;
        e_vis = 0;
        e_idx = 0;
        for (int i = 0; i < N; i++) begin
            d2 = (kx - ox[i]) * (kx - ox[i])
               + (ky - oy[i]) * (ky - oy[i]);
            if (kd[i] == 0 && d2 <= 23*23 && !e_hit) begin
                e_hit = 1;
                e_idx = i;
            end
            if (kd[i] == 1 && d2 <= 26*26 && !e_hit) begin
                e_hit = 1;
                e_idx = i;
            end
            if (kd[i] == 0 && i < 4 && d2 <= 37*37)
                e_vis = 1;
            if (kd[i] == 2 && d2 <= 37*37)
                e_vis = 1;
        end
    endtask

    task automatic scan(input int kx, input int ky, input bit fk,
                        input bit clr_end, input bit poke);
        int n;
        @(negedge Clk);
        kid_x = W'(kx);
        kid_y = W'(ky);
        force_kill = fk;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        kid_x = '0;
        kid_y = '0;
        force_kill = 1'b0;
        n = 1;
        chk("busy_c1", busy, 1);
        while (!done && n < 60) begin
            start = poke && (n == 5);
            if (clr_end && n == 26)
                kill_clr = 1'b1;
            @(negedge Clk);
            n++;
        end
        lat = n;
        chk("latency", n, 27);
        chk("busy_done", busy, 0);
        if (poke)
            start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        kill_clr = 1'b0;
        chk("done_pulse", done, 0);
        if (poke)
            chk("start_in_done", busy, 0);
    endtask

    task automatic pulse_clr();
        @(negedge Clk);
        kill_clr = 1'b1;
        @(negedge Clk);
        kill_clr = 1'b0;
        m_kill = 0;
    endtask

    initial begin
        int kx;
        int ky;
        int ndone;
        bit fk;
        clear_objs();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_kill", is_kill, 0);
        chk("rst_vis", visited, 0);
        chk("rst_hv", hit_valid, 0);
        chk("rst_idx", hit_idx, 0);
        @(negedge Clk);
        Reset = 1'b1;

        ox[0] = 116; oy[0] = 116; kd[0] = 0;
        scan(100, 100, 0, 0, 1);
        chk("A_kill", is_kill, 1);
        chk("A_hv", hit_valid, 1);
        chk("A_idx", hit_idx, 0);
        chk("A_vis", visited, 1);

        @(negedge Clk);
        kid_x = 100; kid_y = 100; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (10) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("R_busy", busy, 0);
        chk("R_kill", is_kill, 0);
        chk("R_hv", hit_valid, 0);
        Reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge Clk);
            if (done) ndone++;
        end
        chk("R_nodone", ndone, 0);

        ox[0] = 117;
        scan(100, 100, 0, 0, 0);
        chk("B_kill", is_kill, 0);
        chk("B_hv", hit_valid, 0);
        chk("B_vis", visited, 1);
        clear_objs();
        ox[5] = 117; oy[5] = 116; kd[5] = 0;
        scan(100, 100, 0, 0, 0);
        chk("B5_vis", visited, 0);
        chk("B5_hv", hit_valid, 0);

        clear_objs();
        ox[3] = 26; oy[3] = 0; kd[3] = 1;
        ox[7] = 0;  oy[7] = 26; kd[7] = 1;
        scan(0, 0, 0, 0, 0);
        chk("C_hv", hit_valid, 1);
        chk("C_idx", hit_idx, 3);
        chk("C_kill", is_kill, 1);
        pulse_clr();
        chk("C_clr", is_kill, 0);

        clear_objs();
        ox[9] = 100; oy[9] = 100; kd[9] = 2;
        ox[12] = 137; oy[12] = 100; kd[12] = 0;
        scan(100, 100, 0, 0, 0);
        chk("D2_vis", visited, 1);
        chk("D2_kill", is_kill, 0);
        chk("D2_idx", hit_idx, 0);
        kd[9] = 3;
        scan(100, 100, 0, 0, 0);
        chk("D3_vis", visited, 0);
        chk("D3_kill", is_kill, 0);
        ox[9] = 137; kd[9] = 2;
        scan(100, 100, 0, 0, 0);
        chk("Dv_edge", visited, 1);
        ox[9] = 138;
        scan(100, 100, 0, 0, 0);
        chk("Dv_out", visited, 0);

        clear_objs();
        scan(100, 100, 1, 1, 0);
        chk("E_kill", is_kill, 1);
        chk("E_hv", hit_valid, 0);
        pulse_clr();
        chk("E_clr", is_kill, 0);

        for (int t = 0; t < 12; t++) begin
            kx = int'($urandom_range(100, 900));
            ky = int'($urandom_range(100, 900));
            for (int i = 0; i < N; i++) begin
                ox[i] = kx + int'($urandom_range(0, 80)) - 40;
                oy[i] = ky + int'($urandom_range(0, 80)) - 40;
                kd[i] = int'($urandom_range(0, 3));
            end
            fk = ($urandom_range(0, 3) == 0);
            model(kx, ky);
            scan(kx, ky, fk, 0, t[0]);
            m_kill = m_kill | e_hit | fk;
            chk("rnd_hv", hit_valid, 32'(e_hit));
            chk("rnd_idx", hit_idx, e_idx);
            chk("rnd_vis", visited, 32'(e_vis));
            chk("rnd_kill", is_kill, 32'(m_kill));
            if (t % 3 == 2) begin
                pulse_clr();
                chk("rnd_clr", is_kill, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
